// File: rtl/pong_kb_pkg.sv
// Shared constants and types for the PS/2 keyboard front end of Pong.
package pong_kb_pkg;

    // Scan codes the key decoder cares about (set 2).
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    // Frame receiver states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw lines, detects kbClock falling
// edges, deserialises start/8 data/parity/stop and flags good or bad bytes.
module ps2_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbClock,
    input  logic       kbData,
    output logic       byte_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);
    import pong_kb_pkg::*;

    localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall_s;

    rx_state_e              state_r, state_s;
    logic [2:0]             bit_cnt_r, bit_cnt_s;
    logic [7:0]             shift_r, shift_s;
    logic                   par_r, par_s;
    logic [TIMEOUT_W-1:0]   tmo_r, tmo_s;
    logic                   byte_valid_r, byte_valid_s;
    logic                   frame_err_r, frame_err_s;
    logic [7:0]             scan_code_r, scan_code_s;

    // Synchroniser chains; reset to the idle-high line level so release never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], kbClock};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], kbData};
            clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    assign clk_s  = clk_sync_r[SYNC_STAGES-1];
    assign data_s = data_sync_r[SYNC_STAGES-1];
    assign fall_s = clk_prev_r & ~clk_s;

    // Next-state logic: bit sequencing on falling edges, inter-edge timeout otherwise.
    always_comb begin
        state_s      = state_r;
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        par_s        = par_r;
        tmo_s        = tmo_r;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;
        scan_code_s  = scan_code_r;
        if (state_r == IDLE) begin
            tmo_s = {TIMEOUT_W{1'b0}};
            if (fall_s && !data_s) begin
                state_s   = DATA;
                bit_cnt_s = 3'd0;
            end else begin
                state_s = IDLE;
            end
        end else if (fall_s) begin
            tmo_s = {TIMEOUT_W{1'b0}};
            case (state_r)
                DATA: begin
                    shift_s = {data_s, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_s = PARITY;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end
                PARITY: begin
                    par_s   = data_s;
                    state_s = STOP;
                end
                STOP: begin
                    if (data_s && odd_parity_ok(shift_r, par_r)) begin
                        byte_valid_s = 1'b1;
                        scan_code_s  = shift_r;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else if (tmo_r == TMO_LIMIT) begin
            // Stalled frame: drop it without signalling anything.
            state_s = IDLE;
            tmo_s   = {TIMEOUT_W{1'b0}};
        end else begin
            tmo_s = tmo_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
    end

    // Receiver state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            par_r        <= 1'b0;
            tmo_r        <= {TIMEOUT_W{1'b0}};
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            scan_code_r  <= 8'h00;
        end else begin
            state_r      <= state_s;
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            par_r        <= par_s;
            tmo_r        <= tmo_s;
            byte_valid_r <= byte_valid_s;
            frame_err_r  <= frame_err_s;
            scan_code_r  <= scan_code_s;
        end
    end

    assign byte_valid = byte_valid_r;
    assign frame_err  = frame_err_r;
    assign scan_code  = scan_code_r;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder for Pong: turns received scan codes into held-key levels
// for the left (W/S) and right (arrow up/down) paddles.
module ps2_key_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int TIMEOUT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbClock,
    input  logic       kbData,
    output logic       leftUp,
    output logic       leftDown,
    output logic       rightUp,
    output logic       rightDown,
    output logic       byte_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);
    import pong_kb_pkg::*;

    logic       rx_valid_s;
    logic       rx_err_s;
    logic [7:0] rx_code_s;

    logic ext_r, ext_s;
    logic brk_r, brk_s;
    logic left_up_r, left_up_s;
    logic left_down_r, left_down_s;
    logic right_up_r, right_up_s;
    logic right_down_r, right_down_s;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_W     (TIMEOUT_W)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .kbClock   (kbClock),
        .kbData    (kbData),
        .byte_valid(rx_valid_s),
        .scan_code (rx_code_s),
        .frame_err (rx_err_s)
    );

    // Prefix tracking and key updates; a key code consumes the E0/F0 prefixes.
    always_comb begin
        ext_s        = ext_r;
        brk_s        = brk_r;
        left_up_s    = left_up_r;
        left_down_s  = left_down_r;
        right_up_s   = right_up_r;
        right_down_s = right_down_r;
        if (rx_valid_s) begin
            if (rx_code_s == SC_EXT) begin
                ext_s = 1'b1;
            end else if (rx_code_s == SC_BREAK) begin
                brk_s = 1'b1;
            end else begin
                if (!ext_r && rx_code_s == SC_W) begin
                    left_up_s = !brk_r;
                end else if (!ext_r && rx_code_s == SC_S) begin
                    left_down_s = !brk_r;
                end else if (ext_r && rx_code_s == SC_UP) begin
                    right_up_s = !brk_r;
                end else if (ext_r && rx_code_s == SC_DOWN) begin
                    right_down_s = !brk_r;
                end else begin
                    left_up_s = left_up_r;
                end
                ext_s = 1'b0;
                brk_s = 1'b0;
            end
        end else if (rx_err_s) begin
            // A corrupted byte may have been a key code: forget any pending prefix.
            ext_s = 1'b0;
            brk_s = 1'b0;
        end else begin
            ext_s = ext_r;
        end
    end

    // Prefix flags and key level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_r        <= 1'b0;
            brk_r        <= 1'b0;
            left_up_r    <= 1'b0;
            left_down_r  <= 1'b0;
            right_up_r   <= 1'b0;
            right_down_r <= 1'b0;
        end else begin
            ext_r        <= ext_s;
            brk_r        <= brk_s;
            left_up_r    <= left_up_s;
            left_down_r  <= left_down_s;
            right_up_r   <= right_up_s;
            right_down_r <= right_down_s;
        end
    end

    assign leftUp     = left_up_r;
    assign leftDown   = left_down_r;
    assign rightUp    = right_up_r;
    assign rightDown  = right_down_r;
    assign byte_valid = rx_valid_s;
    assign scan_code  = rx_code_s;
    assign frame_err  = rx_err_s;

endmodule
